// File: rtl/dt_mem_host.sv
// dt_mem_host: memory-side responder for the distance-transform engine.
// Owns the 1024x16 image ROM (sti) and the 16384x8 result RAM (res).
// Sequence: clear res, load the image from the host stream, release the
// engine, then stream the finished result map back to the host.
// Ports:
//   clk, reset (sync, active-low)
//   load_valid/load_data/load_ready : host image stream, words 0..1023
//   dt_rst_n, dt_done               : engine reset / done handshake
//   sti_rd/sti_addr/sti_di          : engine image reads (combinational)
//   res_rd/res_wr/res_addr/res_do/res_di : engine result RAM access
//   dump_valid/dump_ready/dump_addr/dump_data/dump_last : result stream
//   finished                        : level, high once the dump is complete
module dt_mem_host (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic        dt_rst_n,
  input  logic        dt_done,
  input  logic        sti_rd,
  input  logic [9:0]  sti_addr,
  output logic [15:0] sti_di,
  input  logic        res_rd,
  input  logic        res_wr,
  input  logic [13:0] res_addr,
  input  logic [7:0]  res_do,
  output logic [7:0]  res_di,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [13:0] dump_addr,
  output logic [7:0]  dump_data,
  output logic        dump_last,
  output logic        finished
);

  localparam int unsigned STI_WORDS = 1024;
  localparam int unsigned RES_DEPTH = 16384;
  localparam int unsigned STI_AW    = 10;
  localparam int unsigned RES_AW    = 14;
  localparam int unsigned STI_DW    = 16;
  localparam int unsigned RES_DW    = 8;

  localparam logic [RES_AW-1:0] CNT_MAX  = RES_AW'(RES_DEPTH - 1);
  localparam logic [RES_AW-1:0] STI_LAST = RES_AW'(STI_WORDS - 1);

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DUMP  = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  logic [STI_DW-1:0] r_sti [STI_WORDS];
  logic [RES_DW-1:0] r_res [RES_DEPTH];

  logic [2:0]        r_state;
  logic [RES_AW-1:0] r_cnt;
  logic              r_load_ready;
  logic              r_dt_rst_n;
  logic              r_dump_valid;
  logic              r_finished;

  logic [2:0]        w_state_nxt;
  logic [RES_AW-1:0] w_cnt_nxt;
  logic              w_load_acc;
  logic              w_dump_acc;
  logic              w_res_we;
  logic [RES_AW-1:0] w_res_wa;
  logic [RES_DW-1:0] w_res_wd;

  // load_ready / dump_valid are only ever high in LOAD / DUMP respectively
  assign w_load_acc = load_valid && r_load_ready;
  assign w_dump_acc = r_dump_valid && dump_ready;

  // State and counter register; flag outputs follow the next state so they
  // line up with the state they describe
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_CLEAR;
      r_cnt        <= '0;
      r_load_ready <= 1'b0;
      r_dt_rst_n   <= 1'b0;
      r_dump_valid <= 1'b0;
      r_finished   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_load_ready <= (w_state_nxt == S_LOAD);
      r_dt_rst_n   <= (w_state_nxt == S_RUN);
      r_dump_valid <= (w_state_nxt == S_DUMP);
      r_finished   <= (w_state_nxt == S_END);
    end
  end

  // Next-state and shared counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_CLEAR: begin
        if (r_cnt == CNT_MAX) w_state_nxt = S_LOAD;
        else                  w_cnt_nxt   = r_cnt + RES_AW'(1);
      end
      S_LOAD: begin
        if (w_load_acc) begin
          if (r_cnt == STI_LAST) w_state_nxt = S_RUN;
          else                   w_cnt_nxt   = r_cnt + RES_AW'(1);
        end
      end
      S_RUN: begin
        if (dt_done) w_state_nxt = S_DUMP;
      end
      S_DUMP: begin
        if (w_dump_acc) begin
          if (r_cnt == CNT_MAX) w_state_nxt = S_END;
          else                  w_cnt_nxt   = r_cnt + RES_AW'(1);
        end
      end
      S_END: begin
        w_state_nxt = S_END;
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
    // counter restarts from zero on every state change
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  // Single RAM write port: zero fill during CLEAR, engine writes during RUN
  always_comb begin
    w_res_we = 1'b0;
    w_res_wa = r_cnt;
    w_res_wd = '0;
    if (r_state == S_CLEAR) begin
      w_res_we = 1'b1;
    end else if ((r_state == S_RUN) && res_wr) begin
      w_res_we = 1'b1;
      w_res_wa = res_addr;
      w_res_wd = res_do;
    end
  end

  // Memory arrays are not reset; writes are suppressed while reset is low
  always_ff @(posedge clk) begin
    if (reset && w_res_we) r_res[w_res_wa] <= w_res_wd;
    if (reset && w_load_acc) r_sti[r_cnt[STI_AW-1:0]] <= load_data;
  end

  // Combinational engine reads: the engine samples one edge after the address
  assign sti_di = ((r_state == S_RUN) && sti_rd) ? r_sti[sti_addr] : '0;
  assign res_di = ((r_state == S_RUN) && res_rd) ? r_res[res_addr] : '0;

  assign load_ready = r_load_ready;
  assign dt_rst_n   = r_dt_rst_n;
  assign dump_valid = r_dump_valid;
  assign dump_addr  = r_cnt;
  assign dump_data  = r_res[r_cnt];
  assign dump_last  = r_dump_valid && (r_cnt == CNT_MAX);
  assign finished   = r_finished;

endmodule

// File: tb/tb_dt_mem_host.sv
// tb_dt_mem_host: bench for dt_mem_host. The bench plays host and engine;
// dump bytes are checked against a golden result map through a queue.
module tb_dt_mem_host;

  localparam int unsigned STI_WORDS = 1024;
  localparam int unsigned RES_DEPTH = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        dt_rst_n;
  logic        dt_done;
  logic        sti_rd;
  logic [9:0]  sti_addr;
  logic [15:0] sti_di;
  logic        res_rd;
  logic        res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic [7:0]  res_di;
  logic        dump_valid;
  logic        dump_ready;
  logic [13:0] dump_addr;
  logic [7:0]  dump_data;
  logic        dump_last;
  logic        finished;

  dt_mem_host dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .dt_rst_n   (dt_rst_n),
    .dt_done    (dt_done),
    .sti_rd     (sti_rd),
    .sti_addr   (sti_addr),
    .sti_di     (sti_di),
    .res_rd     (res_rd),
    .res_wr     (res_wr),
    .res_addr   (res_addr),
    .res_do     (res_do),
    .res_di     (res_di),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .finished   (finished)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
    logic        last;
  } dump_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] img     [STI_WORDS];
  logic [7:0]  exp_res [RES_DEPTH];
  dump_t       exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: sample at the falling edge, compare every handshake
  logic [13:0] stall_addr;
  logic [7:0]  stall_data;
  logic        stall_pend = 1'b0;
  initial begin
    dump_t e;
    forever begin
      @(negedge clk);
      if (stall_pend && dump_valid) begin
        check("dump_hold_addr", 32'(dump_addr), 32'(stall_addr));
        check("dump_hold_data", 32'(dump_data), 32'(stall_data));
      end
      stall_pend = 1'b0;
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL dump_extra: got addr %0h expected no byte", dump_addr);
        end else begin
          e = exp_q.pop_front();
          check("dump_addr", 32'(dump_addr), 32'(e.addr));
          check("dump_data", 32'(dump_data), 32'(e.data));
          check("dump_last", 32'(dump_last), 32'(e.last));
        end
      end else if (dump_valid) begin
        stall_pend = 1'b1;
        stall_addr = dump_addr;
        stall_data = dump_data;
      end
    end
  end

  // Watchdog
  initial begin
    #(95000 * 10);
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

  // Count cycles from reset release until load_ready rises
  task automatic wait_clear();
    int c = 0;
    while (c < 20000) begin
      @(posedge clk);
      #1;
      c++;
      if (load_ready) break;
    end
    check("clear_cycles", 32'(c), 32'd16384);
  endtask

  // Stream n words with random valid gaps
  task automatic load_words(input bit junk, input int n, output bit early_rise);
    int idx = 0;
    int it  = 0;
    bit v;
    bit rdy;
    early_rise = 1'b0;
    while (idx < n && it < 5000) begin
      @(negedge clk);
      v          = ($urandom_range(0, 3) != 0);
      load_valid = v;
      load_data  = junk ? (16'hA5A5 ^ 16'(idx)) : img[idx];
      rdy        = load_ready;
      if (dt_rst_n) early_rise = 1'b1;
      @(posedge clk);
      #1;
      it++;
      if (v && rdy) idx++;
    end
    check("load_count", 32'(idx), 32'(n));
  endtask

  initial begin
    bit early;
    int d;
    reset = 1'b0; load_valid = 1'b0; load_data = '0; dt_done = 1'b0;
    sti_rd = 1'b0; sti_addr = '0; res_rd = 1'b0; res_wr = 1'b0;
    res_addr = '0; res_do = '0; dump_ready = 1'b0;

    // Image: 5x5 square at x,y = 60..64; golden distance map 1/2/3
    for (int i = 0; i < int'(STI_WORDS); i++) img[i] = '0;
    for (int i = 0; i < int'(RES_DEPTH); i++) exp_res[i] = '0;
    for (int y = 60; y <= 64; y++) begin
      img[y*8+3] = 16'h000F;
      img[y*8+4] = 16'h8000;
      for (int x = 60; x <= 64; x++) begin
        d = x - 59;
        if (65 - x < d) d = 65 - x;
        if (y - 59 < d) d = y - 59;
        if (65 - y < d) d = 65 - y;
        exp_res[y*128+x] = 8'(d);
      end
    end
    exp_res[300] = 8'h07;

    repeat (2) @(posedge clk);
    #1;
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_dt_rst_n",   32'(dt_rst_n),   32'd0);
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    check("rst_dump_last",  32'(dump_last),  32'd0);
    check("rst_finished",   32'(finished),   32'd0);

    @(negedge clk) reset = 1'b1;
    wait_clear();

    // Partial load of throwaway data, then reset mid-LOAD
    load_words(1'b1, 500, early);
    @(negedge clk);
    load_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_load_ready", 32'(load_ready), 32'd0);
    check("midrst_dt_rst_n",   32'(dt_rst_n),   32'd0);
    @(negedge clk) reset = 1'b1;
    wait_clear();

    // Full load; dt_rst_n must rise right after the last accepted word
    load_words(1'b0, int'(STI_WORDS), early);
    check("dt_rst_n_early", 32'(early), 32'd0);
    check("dt_rst_n_rise",  32'(dt_rst_n), 32'd1);
    check("load_ready_off", 32'(load_ready), 32'd0);
    @(negedge clk) load_valid = 1'b0;

    // Engine image reads
    sti_rd = 1'b1; sti_addr = 10'd5;
    #1 check("sti_addr5", 32'(sti_di), 32'(img[5]));
    for (int a = 0; a < int'(STI_WORDS); a++) begin
      @(negedge clk) sti_addr = 10'(a);
      #1 check("sti_word", 32'(sti_di), 32'(img[a]));
    end
    @(negedge clk) sti_addr = 10'd483;
    #1 check("sti_rd_hi", 32'(sti_di), 32'h000F);
    sti_rd = 1'b0;
    #1 check("sti_rd_lo", 32'(sti_di), 32'd0);

    // Read and write same address in one cycle: old value first
    @(negedge clk);
    res_rd = 1'b1; res_addr = 14'd300; res_wr = 1'b1; res_do = 8'h07;
    #1 check("res_rw_old", 32'(res_di), 32'd0);
    @(negedge clk) res_wr = 1'b0;
    #1 check("res_rw_new", 32'(res_di), 32'h07);

    // Engine writes the golden distance map for the square
    for (int y = 60; y <= 64; y++) begin
      for (int x = 60; x <= 64; x++) begin
        @(negedge clk);
        res_wr = 1'b1; res_addr = 14'(y*128+x); res_do = exp_res[y*128+x];
      end
    end
    @(negedge clk);
    res_wr = 1'b0; res_addr = 14'(62*128+62);
    #1 check("res_centre", 32'(res_di), 32'd3);
    res_rd = 1'b0;
    #1 check("res_rd_lo", 32'(res_di), 32'd0);

    for (int i = 0; i < int'(RES_DEPTH); i++)
      exp_q.push_back({14'(i), exp_res[i], (i == int'(RES_DEPTH) - 1)});

    @(negedge clk) dt_done = 1'b1;
    @(posedge clk);
    #1;
    check("done_dt_rst_n",  32'(dt_rst_n),   32'd0);
    check("done_dump_vld",  32'(dump_valid), 32'd1);
    check("done_dump_addr", 32'(dump_addr),  32'd0);

    // Outside RUN: reads return 0 and writes are dropped (addr 100 stays 0)
    @(negedge clk);
    dt_done = 1'b0;
    sti_rd = 1'b1; sti_addr = 10'd483;
    res_rd = 1'b1; res_addr = 14'd300;
    #1;
    check("dump_sti_di", 32'(sti_di), 32'd0);
    check("dump_res_di", 32'(res_di), 32'd0);
    res_wr = 1'b1; res_addr = 14'd100; res_do = 8'h55;

    // Dump with dump_ready toggling
    for (int c = 0; c < 40000; c++) begin
      @(posedge clk);
      #1;
      if (finished) break;
      dump_ready = ~dump_ready;
    end
    check("finished",     32'(finished),     32'd1);
    check("end_dump_vld", 32'(dump_valid),   32'd0);
    check("end_dt_rst_n", 32'(dt_rst_n),     32'd0);
    check("end_last",     32'(dump_last),    32'd0);
    check("dump_pending", 32'(exp_q.size()), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check("end_hold_fin", 32'(finished),   32'd1);
    check("end_hold_vld", 32'(dump_valid), 32'd0);
    check("end_res_di",   32'(res_di),     32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
